imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the IF fetch path and the program loader/debug port.
//  - Arbitration is round-robin.
//  - The loader can take a bounded locked burst for bulk writes.
//  - Read data returns one cycle after the grant.
//  - stall_if tells IF to hold its PC while it is denied the memory.
// PARAMETERS
//  ADDR_W     32  byte-address width of both requesters
//  DATA_W     32  instruction/data word width
//  BURST_MAX  8   max consecutive loader grants while l_lock=1 (range 1..255)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  f_req      in   1           fetch request (IF holds until f_gnt)
//  f_addr     in   ADDR_W      fetch byte address (PC)
//  f_gnt      out  1           fetch granted this cycle (combinational)
//  f_rvalid   out  1           f_rdata valid (registered, 1 cycle after f_gnt)
//  f_rdata    out  DATA_W      fetched instruction
//  stall_if   out  1           f_req & ~f_gnt
//  l_req      in   1           loader request (held until l_gnt)
//  l_we       in   1           loader write enable
//  l_lock     in   1           loader requests locked burst
//  l_addr     in   ADDR_W      loader byte address
//  l_wdata    in   DATA_W      loader write data
//  l_gnt      out  1           loader granted this cycle (combinational)
//  l_rvalid   out  1           l_rdata valid (reads only; 1 cycle after l_gnt)
//  l_rdata    out  DATA_W      loader read data
//  mem_en     out  1           memory access strobe
//  mem_we     out  1           memory write strobe
//  mem_addr   out  ADDR_W-2    word address = granted addr[ADDR_W-1:2]
//  mem_wdata  out  DATA_W      memory write data
//  mem_rdata  in   DATA_W      memory read data, valid cycle after mem_en
//  misalign   out  1           registered pulse: granted addr[1:0]!=0
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=ARB, last=LOADER, burst_cnt=0, pending rvalids cleared.
//   - f_rvalid, l_rvalid, misalign = 0; f_rdata, l_rdata = 0.
//   - mem_en, mem_we, f_gnt, l_gnt = 0 while rst=1.
//  Grant rules:
//   - At most one of f_gnt/l_gnt per cycle. mem_en = f_gnt|l_gnt.
//   - mem_we = l_gnt&l_we. Fetch never writes.
//   - Mux: mem_addr/mem_wdata driven from the granted requester; 0 when idle.
//  State ARB:
//   - Only one req -> grant it.
//   - Both req -> grant the one not equal to last. last updates on every grant.
//   - l_gnt with l_lock=1 -> LOCK; burst_cnt=1.
//  State LOCK:
//   - f_gnt=0. l_gnt=l_req. burst_cnt increments per l_gnt.
//   - LOCK->ARB (next cycle) when any of: l_lock=0 at a cycle edge, l_req=0, or burst_cnt==BURST_MAX after a grant.
//   - Exit sets last=LOADER, so a waiting fetch wins the next tie.
//   - The loader cannot re-enter LOCK before one fetch grant if f_req is pending.
//  Read return (latency exactly 1 cycle):
//   - f_rvalid <= f_gnt. l_rvalid <= l_gnt&~l_we.
//   - The rdata of the selected requester is captured from mem_rdata in that cycle.
//   - The other requester's rdata holds its previous value.
//  misalign:
//   - Pulses 1 cycle after a grant whose addr[1:0]!=0.
//   - The access still proceeds with the truncated word address.
//  Back-to-back:
//   - A new grant may issue every cycle. Fetch streams at 1 word/cycle when uncontended.
//  Reset mid-operation:
//   - A grant in the reset cycle is discarded. No rvalid follows reset release.
//   - The FSM restarts in ARB.
//  Simultaneous l_lock drop and BURST_MAX reached: single exit to ARB, no double count.
// TESTING
//  T1 fetch only:
//   - Stimulus: f_req=1, f_addr=0,4,8; mem word[n]=n+0x100.
//   - Response: f_gnt every cycle, stall_if=0; f_rvalid 1 cycle later with 0x100,0x101,0x102.
//  T2 contention after reset:
//   - Stimulus: f_req=l_req=1, l_we=0, l_addr=0x40.
//   - Response: grants F,L,F,L...; stall_if=1 on L cycles; l_rdata=word[0x10].
//  T3 locked burst:
//   - Stimulus: l_lock=1, l_we=1, BURST_MAX=8, 10 writes, f_req=1 throughout.
//   - Response: 8 consecutive l_gnt, then f_gnt, then loader; memory holds written data; l_rvalid never set.
//  T4 misalign:
//   - Stimulus: f_addr=0x6.
//   - Response: mem_addr=1; misalign=1 for exactly one cycle after f_gnt.
//  T5 reset mid-burst:
//   - Stimulus: assert rst during LOCK with a grant in flight.
//   - Response: all outputs 0 immediately, no rvalid after release, first tie goes to fetch.

Source files
------------

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Shares one single-port instruction memory between the IF fetch path and
//   the program loader / debug port. Round-robin arbitration, with an optional
//   bounded locked burst for the loader (bulk writes). Grants are
//   combinational. Read data comes back exactly one cycle after the grant.
//
// Parameters
//   ADDR_W     byte-address width of both requesters
//   DATA_W     instruction / data word width
//   BURST_MAX  max consecutive loader grants while l_lock=1 (1..255)
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   f_req/f_addr          fetch request and byte address (PC)
//   f_gnt                 fetch granted this cycle
//   f_rvalid/f_rdata      fetched instruction, one cycle after f_gnt
//   stall_if              IF must hold its PC (request pending, not granted)
//   l_req/l_we/l_lock     loader request, write enable, locked-burst request
//   l_addr/l_wdata        loader byte address and write data
//   l_gnt                 loader granted this cycle
//   l_rvalid/l_rdata      loader read data, one cycle after a read grant
//   mem_en/mem_we         memory access / write strobes
//   mem_addr/mem_wdata    word address and write data of the granted access
//   mem_rdata             memory read data, valid the cycle after mem_en
//   misalign              one-cycle pulse after a grant with addr[1:0] != 0
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              stall_if,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign
);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  localparam logic       OWNER_FETCH  = 1'b0;
  localparam logic       OWNER_LOADER = 1'b1;
  localparam logic [7:0] BURST_LIMIT  = 8'(BURST_MAX);
  // With a limit of one grant, the entry grant already exhausts the burst,
  // so LOCK is never entered.
  localparam bit         LOCK_ALLOWED = (BURST_MAX > 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              misalign_q, misalign_d;

  logic              gnt_f, gnt_l;
  logic [ADDR_W-1:0] gnt_addr;
  logic [1:0]        ret_en;
  logic [1:0]        rvalid_w;
  logic [DATA_W-1:0] rdata_w [2];

  // ---------------------------------------------------------------------------
  // Grant decision. Grants are suppressed while rst is high so that an access
  // in the reset cycle never reaches the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_f = 1'b0;
    gnt_l = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCK) begin
        gnt_l = l_req;
      end else if (f_req && l_req) begin
        if (last_q == OWNER_LOADER) gnt_f = 1'b1;
        else                        gnt_l = 1'b1;
      end else begin
        gnt_f = f_req;
        gnt_l = l_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: round-robin pointer, lock FSM and burst counter.
  // Leaving LOCK always points "last" at the loader, so a waiting fetch wins
  // the next tie; that is also what stops the loader re-locking ahead of a
  // pending fetch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (gnt_f) last_d = OWNER_FETCH;
    if (gnt_l) last_d = OWNER_LOADER;
    case (state_q)
      ST_ARB: begin
        if (gnt_l && l_lock && LOCK_ALLOWED) begin
          state_d     = ST_LOCK;
          burst_cnt_d = 8'd1;
        end
      end
      ST_LOCK: begin
        burst_cnt_d = burst_cnt_q + {7'd0, gnt_l};
        // All exit causes collapse into one transition, so a lock drop on the
        // same cycle the limit is reached cannot count twice.
        if (!l_lock || !l_req || (burst_cnt_d == BURST_LIMIT)) begin
          state_d     = ST_ARB;
          burst_cnt_d = 8'd0;
          last_d      = OWNER_LOADER;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory-side mux; everything reads as zero when no one is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_addr = '0;
    if (gnt_f)      gnt_addr = f_addr;
    else if (gnt_l) gnt_addr = l_addr;
  end

  assign mem_en     = gnt_f | gnt_l;
  assign mem_we     = gnt_l & l_we;
  assign mem_addr   = gnt_addr[ADDR_W-1:2];
  assign mem_wdata  = gnt_l ? l_wdata : '0;
  assign misalign_d = (gnt_f | gnt_l) && (gnt_addr[1:0] != 2'b00);

  assign f_gnt    = gnt_f;
  assign l_gnt    = gnt_l;
  // Held low during reset so every output is quiet while rst is asserted.
  assign stall_if = f_req & ~gnt_f & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARB;
      last_q      <= OWNER_LOADER;
      burst_cnt_q <= 8'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign misalign = misalign_q;

  // ---------------------------------------------------------------------------
  // Read return, one lane per requester (0 = fetch, 1 = loader). While the
  // lane's rvalid is high the memory output passes straight through and is
  // captured; otherwise the lane keeps showing its last word.
  // ---------------------------------------------------------------------------
  assign ret_en = {gnt_l & ~l_we, gnt_f};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic              rvalid_q;
      logic [DATA_W-1:0] rdata_q, rdata_d;

      always_comb rdata_d = rvalid_q ? mem_rdata : rdata_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= ret_en[gi];
          rdata_q  <= rdata_d;
        end
      end

      assign rvalid_w[gi] = rvalid_q;
      assign rdata_w[gi]  = rdata_d;
    end
  endgenerate

  assign f_rvalid = rvalid_w[0];
  assign f_rdata  = rdata_w[0];
  assign l_rvalid = rvalid_w[1];
  assign l_rdata  = rdata_w[1];

endmodule
